// File: rtl/reducao_media_2x2.sv
// reducao_media_2x2: streaming 2:1 downscaler. Each 2x2 block of a raster
// stream (input width 2*LARGURA_IMAGEM) becomes one pixel equal to the mean
// of the four pixels, rounded half up. Even rows store horizontal pair sums
// in a one-line buffer; odd rows complete each block and emit the result.
module reducao_media_2x2 #(
   parameter int unsigned LARGURA_IMAGEM = 4,
   parameter int unsigned LARGURA_PIXEL  = 8,
   parameter int unsigned LARGURA_MAXIMA = 320
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     pixel_in_valid,
   input  logic [LARGURA_PIXEL-1:0] pixel_in,
   input  logic                     sof,
   output logic                     pixel_out_valid,
   output logic [LARGURA_PIXEL-1:0] pixel_out,
   output logic                     pixel_out_last
);

   localparam int unsigned W  = LARGURA_IMAGEM;
   localparam int unsigned P  = LARGURA_PIXEL;
   // x_in spans one input row (2*W pixels)
   localparam int unsigned XW = ($clog2(2 * W) > 1) ? $clog2(2 * W) : 1;
   // line buffer address: one entry per output column
   localparam int unsigned AW = (W > 1) ? $clog2(W) : 1;
   localparam logic [XW-1:0] X_ULTIMO = XW'(2 * W - 1);

   localparam logic [0:0] S_LINHA_PAR   = 1'b0;
   localparam logic [0:0] S_LINHA_IMPAR = 1'b1;

   // Reject widths the line buffer was not sized for
   generate
      if (LARGURA_IMAGEM < 1 || LARGURA_IMAGEM > LARGURA_MAXIMA) begin : g_largura_invalida
         $fatal(1, "reducao_media_2x2: LARGURA_IMAGEM fora do intervalo 1..LARGURA_MAXIMA");
      end
   endgenerate

   // Row state (doubles as row parity), column counter, hold register
   logic [0:0]    estado;
   logic [0:0]    estado_prox;
   logic [XW-1:0] x_in;
   logic [XW-1:0] x_prox;
   logic [P-1:0]  retido;
   logic [P-1:0]  retido_prox;

   // Registered outputs and their next values
   logic          valid_prox;
   logic [P-1:0]  out_prox;
   logic          last_prox;

   // One-line buffer of horizontal pair sums from the even row
   logic [P:0]    linha_soma [W];
   logic          escreve;
   logic [AW-1:0] endereco;
   logic [P:0]    leitura;

   // Effective position of the current pixel after sof resync
   logic          sincroniza;
   logic [0:0]    estado_ef;
   logic [XW-1:0] x_ef;
   logic          ultimo;

   // Arithmetic
   logic [P:0]    soma_h;
   logic [P+1:0]  total;
   logic [P+1:0]  media;

   // A sof pixel is treated as column 0 of an even row regardless of counters
   always_comb begin
      sincroniza = pixel_in_valid & sof;
      estado_ef  = sincroniza ? S_LINHA_PAR : estado;
      x_ef       = sincroniza ? '0 : x_in;
      ultimo     = (x_ef == X_ULTIMO);
      endereco   = AW'(x_ef >> 1);
   end

   // Buffer read and the pair / block sums; no read-write collision since
   // an address is written in the even row and read only in the next odd row
   always_comb begin
      leitura = linha_soma[endereco];
      soma_h  = (P+1)'(retido) + (P+1)'(pixel_in);
      total   = (P+2)'(leitura) + (P+2)'(retido) + (P+2)'(pixel_in);
      media   = total + (P+2)'(2);
   end

   // Next-state, counter, hold register and output decode
   always_comb begin
      estado_prox = estado;
      x_prox      = x_in;
      retido_prox = retido;
      escreve     = 1'b0;
      valid_prox  = 1'b0;
      out_prox    = pixel_out;
      last_prox   = 1'b0;

      if (pixel_in_valid) begin
         if (ultimo) begin
            x_prox      = '0;
            estado_prox = ~estado_ef;
         end else begin
            x_prox      = x_ef + XW'(1);
            estado_prox = estado_ef;
         end

         if (!x_ef[0]) begin
            retido_prox = pixel_in;
         end else if (estado_ef == S_LINHA_PAR) begin
            escreve = 1'b1;
         end else begin
            valid_prox = 1'b1;
            out_prox   = media[P+1:2];
            last_prox  = ultimo;
         end
      end
   end

   // State, counter, hold register and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         estado          <= S_LINHA_PAR;
         x_in            <= '0;
         retido          <= '0;
         pixel_out_valid <= 1'b0;
         pixel_out       <= '0;
         pixel_out_last  <= 1'b0;
      end else begin
         estado          <= estado_prox;
         x_in            <= x_prox;
         retido          <= retido_prox;
         pixel_out_valid <= valid_prox;
         pixel_out       <= out_prox;
         pixel_out_last  <= last_prox;
      end
   end

   // Line buffer write; contents are don't-care until written by an even row
   always_ff @(posedge clk) begin
      if (escreve) begin
         linha_soma[endereco] <= soma_h;
      end
   end

endmodule
